// File: rtl/effect_chain_xfade.sv
// Serial N-stage effect chain: each stage crossfades between a latency-matched dry copy and its
// external effect return. Optional peak meter on the output when EFFECT_CHAIN_PEAK_EN is defined.
module effect_chain_xfade #(
  parameter int                      DATA_WIDTH = 32,
  parameter int                      NUM_STAGES = 4,
  parameter logic [NUM_STAGES*8-1:0] STAGE_LAT  = {NUM_STAGES{8'd1}},
  parameter int                      FADE_BITS  = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_valid,
  input  logic [DATA_WIDTH-1:0]            audio_in,
  output logic [DATA_WIDTH-1:0]            audio_out,
  output logic                             audio_out_valid,
  input  logic [NUM_STAGES-1:0]            enable,
  output logic [NUM_STAGES*DATA_WIDTH-1:0] fx_send_data,
  output logic [NUM_STAGES-1:0]            fx_send_valid,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] fx_ret_data,
  input  logic [NUM_STAGES-1:0]            fx_ret_valid,
  output logic [NUM_STAGES-1:0]            fading,
`ifdef EFFECT_CHAIN_PEAK_EN
  input  logic                             peak_clr,
  output logic [DATA_WIDTH-2:0]            peak_level,
`endif
  output logic                             align_err
);

  localparam int DW = DATA_WIDTH;
  localparam int GW = FADE_BITS + 1;
  localparam int PW = DW + FADE_BITS + 2;
  localparam logic [GW-1:0] G_MAX = {1'b1, {FADE_BITS{1'b0}}};

  typedef enum logic [1:0] {BYPASS, FADE_IN, WET, FADE_OUT} state_t;

  // Slot 0 is the chain input, slot i+1 is the mix output of stage i.
  logic [(NUM_STAGES+1)*DW-1:0] chain_data;
  logic [NUM_STAGES:0]          chain_valid;
  logic [NUM_STAGES-1:0]        err_hit;

  assign chain_data[DW-1:0] = audio_in;
  assign chain_valid[0]     = sample_valid;

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      localparam int LAT = int'(STAGE_LAT[gi*8 +: 8]);

      logic [DW-1:0]        dly_data [LAT];
      logic                 dly_valid [LAT];
      logic [DW-1:0]        dry;
      logic [DW-1:0]        wet;
      logic [DW-1:0]        mix;
      logic [DW-1:0]        y_reg;
      logic                 dry_v;
      logic                 y_valid_reg;
      logic [GW-1:0]        g_reg;
      logic [GW-1:0]        g_next;
      logic signed [DW:0]   diff;
      logic signed [PW-1:0] prod;
      state_t               state_reg;

      assign fx_send_data[gi*DW +: DW] = chain_data[gi*DW +: DW];
      assign fx_send_valid[gi]         = chain_valid[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < LAT; k++) begin
            dly_data[k]  <= '0;
            dly_valid[k] <= 1'b0;
          end
        end else begin
          dly_data[0]  <= chain_data[gi*DW +: DW];
          dly_valid[0] <= chain_valid[gi];
          for (int k = 1; k < LAT; k++) begin
            dly_data[k]  <= dly_data[k-1];
            dly_valid[k] <= dly_valid[k-1];
          end
        end
      end

      assign dry   = dly_data[LAT-1];
      assign dry_v = dly_valid[LAT-1];
      assign wet   = fx_ret_valid[gi] ? fx_ret_data[gi*DW +: DW] : '0;

      // Gain holds on the sample that changes direction, so fades never jump.
      always_comb begin
        g_next = g_reg;
        if (state_reg == FADE_IN && enable[gi] && g_reg != G_MAX)
          g_next = g_reg + GW'(1);
        else if (state_reg == FADE_OUT && !enable[gi] && g_reg != '0)
          g_next = g_reg - GW'(1);
      end

      assign diff = $signed({wet[DW-1], wet}) - $signed({dry[DW-1], dry});
      assign prod = PW'(diff) * PW'($signed({1'b0, g_next}));
      assign mix  = dry + DW'(prod >>> FADE_BITS);

      assign err_hit[gi] = (state_reg != BYPASS) && (dry_v != fx_ret_valid[gi]);
      assign fading[gi]  = (state_reg == FADE_IN) || (state_reg == FADE_OUT);
      assign chain_data[(gi+1)*DW +: DW] = y_reg;
      assign chain_valid[gi+1]           = y_valid_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg   <= BYPASS;
          g_reg       <= '0;
          y_reg       <= '0;
          y_valid_reg <= 1'b0;
        end else begin
          y_valid_reg <= dry_v;
          if (dry_v) begin
            y_reg <= mix;
            g_reg <= g_next;
            case (state_reg)
              BYPASS:   if (enable[gi]) state_reg <= FADE_IN;
              FADE_IN:  if (!enable[gi]) state_reg <= (g_reg == '0) ? BYPASS : FADE_OUT;
                        else if (g_next == G_MAX) state_reg <= WET;
              WET:      if (!enable[gi]) state_reg <= FADE_OUT;
              FADE_OUT: if (enable[gi]) state_reg <= (g_reg == G_MAX) ? WET : FADE_IN;
                        else if (g_next == '0) state_reg <= BYPASS;
              default:  state_reg <= BYPASS;
            endcase
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audio_out       <= '0;
      audio_out_valid <= 1'b0;
      align_err       <= 1'b0;
    end else begin
      audio_out_valid <= chain_valid[NUM_STAGES];
      if (chain_valid[NUM_STAGES])
        audio_out <= chain_data[NUM_STAGES*DW +: DW];
      if (|err_hit)
        align_err <= 1'b1;
    end
  end

`ifdef EFFECT_CHAIN_PEAK_EN
  logic [DW-2:0] abs_out;

  // The most negative sample has no positive twin; clamp it to full scale.
  always_comb begin
    if (!audio_out[DW-1])
      abs_out = audio_out[DW-2:0];
    else if (audio_out[DW-2:0] == '0)
      abs_out = '1;
    else
      abs_out = (DW-1)'(-audio_out);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      peak_level <= '0;
    else if (peak_clr)
      peak_level <= '0;
    else if (audio_out_valid && abs_out > peak_level)
      peak_level <= abs_out;
  end
`endif

endmodule

// File: tb/tb_effect_chain_xfade.sv
// Randomised and directed bench for effect_chain_xfade: sample-level reference model plus
// per-cycle output checking and hand-computed pins for fades, latency, alignment and reset.
`timescale 1ns/1ps
module tb_effect_chain_xfade;
  localparam int DW    = 32;
  localparam int NS    = 2;
  localparam int FB    = 6;
  localparam int GMAX  = 64;
  localparam int LAT0  = 1;
  localparam int LAT1  = 7;
  localparam int TOTAL = (LAT0 + 1) + (LAT1 + 1) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [31:0]   audio_in = '0;
  logic [31:0]   audio_out;
  logic          audio_out_valid;
  logic [1:0]    enable = '0;
  logic [63:0]   fx_send_data;
  logic [1:0]    fx_send_valid;
  logic [63:0]   fx_ret_data;
  logic [1:0]    fx_ret_valid;
  logic [1:0]    fading;
  logic          align_err;

  effect_chain_xfade #(
    .DATA_WIDTH(DW), .NUM_STAGES(NS), .STAGE_LAT({8'd7, 8'd1}), .FADE_BITS(FB)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .audio_in(audio_in),
    .audio_out(audio_out), .audio_out_valid(audio_out_valid), .enable(enable),
    .fx_send_data(fx_send_data), .fx_send_valid(fx_send_valid),
    .fx_ret_data(fx_ret_data), .fx_ret_valid(fx_ret_valid),
    .fading(fading), .align_err(align_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- external effect models ----------------
  logic [1:0] late = '0;
  logic [1:0] const_mode = '0;
  logic [31:0] fxd [2][9] = '{default: '0};
  logic        fxv [2][9] = '{default: 1'b0};

  function automatic logic signed [31:0] fx(input int i, input logic signed [31:0] x);
    if (const_mode[i]) return 32'sd2000;
    return (i == 0) ? x * 3 : 32'sd777 - x;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 8; k > 0; k--) begin
        fxd[i][k] <= fxd[i][k-1];
        fxv[i][k] <= fxv[i][k-1];
      end
      fxd[i][0] <= fx(i, fx_send_data[i*32 +: 32]);
      fxv[i][0] <= fx_send_valid[i];
    end
  end

  assign fx_ret_data  = {fxd[1][LAT1-1+int'(late[1])], fxd[0][LAT0-1+int'(late[0])]};
  assign fx_ret_valid = {fxv[1][LAT1-1+int'(late[1])], fxv[0][LAT0-1+int'(late[0])]};

  // ---------------- sample-level reference model ----------------
  typedef struct { int t; logic signed [31:0] x; } samp_t;
  samp_t      in_q[$];
  logic [1:0] en_hist [16384];
  int         g_m [2] = '{0, 0};
  bit         dir_m [2] = '{1'b0, 1'b0};
  bit         check_data = 1'b1;
  logic signed [31:0] out_log[$];
  int         out_cyc[$];

  // Walk one sample through every stage, reading enable at the cycle its dry copy reaches the mix.
  function automatic logic signed [31:0] model_out(input int t, input logic signed [31:0] x0);
    logic signed [31:0] x;
    longint wet, y;
    int ct;
    bit en;
    x  = x0;
    ct = t;
    for (int i = 0; i < 2; i++) begin
      ct += (i == 0) ? LAT0 : LAT1;
      en = en_hist[ct % 16384][i];
      if (en != dir_m[i]) dir_m[i] = en;
      else if (en && g_m[i] < GMAX) g_m[i]++;
      else if (!en && g_m[i] > 0) g_m[i]--;
      wet = longint'(fx(i, x));
      y   = longint'(x) + (((wet - longint'(x)) * longint'(g_m[i])) >>> FB);
      x   = y[31:0];
      ct += 1;
    end
    return x;
  endfunction

  always @(negedge clk) begin
    bit exp_v;
    samp_t s;
    logic signed [31:0] y;
    en_hist[cyc % 16384] = enable;
    if (rst) begin
      in_q.delete();
      g_m   = '{0, 0};
      dir_m = '{1'b0, 1'b0};
    end else begin
      exp_v = (in_q.size() > 0) && (in_q[0].t + TOTAL == cyc);
      check("out_valid", longint'(audio_out_valid), longint'(exp_v));
      if (exp_v) begin
        s = in_q.pop_front();
        y = model_out(s.t, s.x);
        if (check_data) check("audio_out", longint'($signed(audio_out)), longint'(y));
        out_log.push_back($signed(audio_out));
        out_cyc.push_back(cyc);
      end
      if (sample_valid) in_q.push_back('{t: cyc, x: audio_in});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [31:0] x);
    sample_valid = 1'b1;
    audio_in     = x;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_audio_out", longint'(audio_out), 0);
    check("rst_out_valid", longint'(audio_out_valid), 0);
    check("rst_fading", longint'(fading), 0);
    check("rst_align_err", longint'(align_err), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    check_reset_state();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1);
  end

  initial begin
    int first_in;
    int max_step;
    int d;
    bit exp_f;
    idle(3);
    check_reset_state();
    rst = 1'b0;
    tick();

    // 1: all stages bypassed, ramp passes through with fixed latency
    enable = 2'b00;
    out_log.delete(); out_cyc.delete();
    first_in = cyc;
    for (int k = 0; k < 100; k++) send(32'(k));
    idle(20);
    check("t1_strobes", out_log.size(), 100);
    if (out_cyc.size() > 0) check("t1_latency", out_cyc[0] - first_in, 11);
    for (int k = 0; k < out_log.size(); k++) check("t1_ramp", out_log[k], k);

    // 2: fade stage 0 in against a constant 2000 wet return
    const_mode = 2'b01;
    enable     = 2'b01;
    out_log.delete();
    for (int k = 0; k < 70; k++) begin
      send(32'd1000);
      if (k == 30) check("t2_fading_mid", longint'(fading[0]), 1);
    end
    idle(20);
    check("t2_count", out_log.size(), 70);
    check("t2_out0", out_log[0], 1000);
    check("t2_out1", out_log[1], 1015);
    check("t2_out2", out_log[2], 1031);
    check("t2_out63", out_log[63], 1984);
    check("t2_out64", out_log[64], 2000);
    check("t2_out69", out_log[69], 2000);
    check("t2_fading_end", longint'(fading[0]), 0);

    // 3: fade out completely, then in to g=32, back to g=20, then up to full wet
    enable = 2'b00;
    for (int k = 0; k < 70; k++) begin send(32'd1000); idle(3); end
    idle(15);
    out_log.delete();
    enable = 2'b01;
    for (int k = 0; k < 33; k++) begin send(32'd1000); idle(3); end
    enable = 2'b00;
    for (int k = 0; k < 13; k++) begin send(32'd1000); idle(3); end
    enable = 2'b01;
    for (int k = 0; k < 45; k++) begin send(32'd1000); idle(3); end
    idle(15);
    check("t3_count", out_log.size(), 91);
    check("t3_g32", out_log[32], 1500);
    check("t3_turn_hold", out_log[33], 1500);
    check("t3_g20", out_log[45], 1312);
    check("t3_turn_hold2", out_log[46], 1312);
    check("t3_g21", out_log[47], 1328);
    check("t3_end_wet", out_log[90], 2000);
    max_step = 0;
    for (int k = 1; k < out_log.size(); k++) begin
      d = int'(out_log[k]) - int'(out_log[k-1]);
      if (d < 0) d = -d;
      if (d > max_step) max_step = d;
    end
    check("t3_step_le_16", longint'(max_step <= 16), 1);

    // 4: late return on stage 1 while enabled -> sticky align_err; same fault bypassed -> none
    const_mode = 2'b00;
    check_data = 1'b0;
    late       = 2'b10;
    enable     = 2'b10;
    for (int k = 0; k < 20; k++) begin send($urandom_range(0, 20000)); idle(2); end
    idle(20);
    check("t4_err_set", longint'(align_err), 1);
    enable = 2'b00;
    idle(30);
    check("t4_err_sticky", longint'(align_err), 1);
    do_reset();
    check_data = 1'b1;
    for (int k = 0; k < 20; k++) begin send($urandom_range(0, 20000)); idle(2); end
    idle(20);
    check("t4_bypass_no_err", longint'(align_err), 0);
    late = 2'b00;
    idle(10);

    // Randomised traffic with random enable changes
    for (int k = 0; k < 1500; k++) begin
      sample_valid = ($urandom % 4) != 0;
      audio_in     = $urandom_range(0, 32'h0200_0000) - 32'h0100_0000;
      if ($urandom % 40 == 0) enable = 2'($urandom);
      tick();
    end
    sample_valid = 1'b0;
    idle(25);
    for (int i = 0; i < 2; i++) begin
      exp_f = (dir_m[i] && g_m[i] < GMAX) || (!dir_m[i] && g_m[i] > 0);
      check("rand_fading", longint'(fading[i]), longint'(exp_f));
    end
    check("rand_align_err", longint'(align_err), 0);

    // 5: reset in the middle of a fade-in, fade restarts from dry
    do_reset();
    const_mode = 2'b01;
    enable     = 2'b01;
    idle(10);
    for (int k = 0; k < 41; k++) send(32'd1000);
    tick();
    check("t5_fading_before_rst", longint'(fading[0]), 1);
    do_reset();
    out_log.delete();
    idle(5);
    check("t5_no_strobe", out_log.size(), 0);
    send(32'd1000); send(32'd1000); send(32'd1000);
    idle(20);
    check("t5_count", out_log.size(), 3);
    check("t5_out0_dry", out_log[0], 1000);
    check("t5_out1", out_log[1], 1015);
    check("t5_out2", out_log[2], 1031);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
